// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU opcodes, forwarding-select encoding
// and the hard-wired zero register index.
package mips_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_NOR  = 4'b1001;
    localparam logic [3:0] ALU_SLLV = 4'b1010;
    localparam logic [3:0] ALU_SRLV = 4'b1011;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle between decode/forwarding sources (master side) and the ID/EX stage
// (slave side). Inputs are sampled on the rising clock; load_use_stall is
// combinational back to decode, everything else out of the stage is registered
// or a pure function of registered state and the forwarding ports.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic [3:0]        id_alu_control;
    logic              id_alu_src;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              id_mem_to_reg;
    logic              stall;
    logic              flush;
    logic              exmem_reg_write;
    logic [REG_AW-1:0] exmem_rd;
    logic [DATA_W-1:0] exmem_result;
    logic              memwb_reg_write;
    logic [REG_AW-1:0] memwb_rd;
    logic [DATA_W-1:0] memwb_result;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_control;
    logic              ex_valid;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_mem_to_reg;
    logic [REG_AW-1:0] ex_rd;
    logic [DATA_W-1:0] ex_store_data;
    logic              load_use_stall;

    modport master (
        output id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
               id_alu_control, id_alu_src, id_reg_write, id_mem_read,
               id_mem_write, id_mem_to_reg, stall, flush,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        input  alu_a, alu_b, alu_control, ex_valid, ex_reg_write, ex_mem_read,
               ex_mem_write, ex_mem_to_reg, ex_rd, ex_store_data, load_use_stall
    );

    modport slave (
        input  id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
               id_alu_control, id_alu_src, id_reg_write, id_mem_read,
               id_mem_write, id_mem_to_reg, stall, flush,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        output alu_a, alu_b, alu_control, ex_valid, ex_reg_write, ex_mem_read,
               ex_mem_write, ex_mem_to_reg, ex_rd, ex_store_data, load_use_stall
    );

endinterface

// File: rtl/forwarding_unit.sv
// Combinational forward-select for the EX operands: the younger EX/MEM result
// beats MEM/WB, and register $0 is never forwarded.
module forwarding_unit
    import mips_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    output fwd_sel_e          fwd_a_sel,
    output fwd_sel_e          fwd_b_sel
);

    localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(REG_ZERO);

    logic w_mem_hit_rs;
    logic w_mem_hit_rt;
    logic w_wb_hit_rs;
    logic w_wb_hit_rt;

    always_comb begin
        w_mem_hit_rs = exmem_reg_write && (exmem_rd != ZERO_ADDR) && (exmem_rd == ex_rs);
        w_mem_hit_rt = exmem_reg_write && (exmem_rd != ZERO_ADDR) && (exmem_rd == ex_rt);
        w_wb_hit_rs  = memwb_reg_write && (memwb_rd != ZERO_ADDR) && (memwb_rd == ex_rs);
        w_wb_hit_rt  = memwb_reg_write && (memwb_rd != ZERO_ADDR) && (memwb_rd == ex_rt);
    end

    always_comb begin
        fwd_a_sel = FWD_REG;
        if (w_mem_hit_rs) begin
            fwd_a_sel = FWD_MEM;
        end else if (w_wb_hit_rs) begin
            fwd_a_sel = FWD_WB;
        end
    end

    always_comb begin
        fwd_b_sel = FWD_REG;
        if (w_mem_hit_rt) begin
            fwd_b_sel = FWD_MEM;
        end else if (w_wb_hit_rt) begin
            fwd_b_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush/bubble control, operand forwarding
// into the ALU and load-use hazard detection.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input logic         clk,
    input logic         rst,
    id_ex_stage_if.slave bus
);

    localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(REG_ZERO);

    logic              r_valid;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_mem_to_reg;
    logic              r_alu_src;
    logic [3:0]        r_alu_control;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_rd;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;

    logic              w_load_use;
    logic              w_take_bubble;
    logic              w_take_id;
    fwd_sel_e          w_fwd_a_sel;
    fwd_sel_e          w_fwd_b_sel;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;

    // Store data (rt) matters even when operand B is the immediate.
    always_comb begin
        w_load_use = r_valid && r_mem_read && (r_rd != ZERO_ADDR) &&
                     ((r_rd == bus.id_rs) ||
                      ((r_rd == bus.id_rt) && !bus.id_alu_src) ||
                      ((r_rd == bus.id_rt) && bus.id_mem_write)) &&
                     !bus.flush;
    end

    always_comb begin
        w_take_bubble = bus.flush ||
                        (!bus.stall && (w_load_use || !bus.id_valid));
        w_take_id     = !bus.stall && !w_take_bubble;
    end

    // A bubble is a cleared slot with ADD opcode, identical to the reset state.
    always_ff @(posedge clk) begin
        if (rst || w_take_bubble) begin
            r_valid       <= 1'b0;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_to_reg  <= 1'b0;
            r_alu_src     <= 1'b0;
            r_alu_control <= ALU_ADD;
            r_rs          <= '0;
            r_rt          <= '0;
            r_rd          <= '0;
            r_rs_data     <= '0;
            r_rt_data     <= '0;
            r_imm         <= '0;
        end else if (w_take_id) begin
            r_valid       <= 1'b1;
            r_reg_write   <= bus.id_reg_write;
            r_mem_read    <= bus.id_mem_read;
            r_mem_write   <= bus.id_mem_write;
            r_mem_to_reg  <= bus.id_mem_to_reg;
            r_alu_src     <= bus.id_alu_src;
            r_alu_control <= bus.id_alu_control;
            r_rs          <= bus.id_rs;
            r_rt          <= bus.id_rt;
            r_rd          <= bus.id_rd;
            r_rs_data     <= bus.id_rs_data;
            r_rt_data     <= bus.id_rt_data;
            r_imm         <= bus.id_imm;
        end
    end

    forwarding_unit #(
        .REG_AW(REG_AW)
    ) u_forwarding_unit (
        .ex_rs          (r_rs),
        .ex_rt          (r_rt),
        .exmem_reg_write(bus.exmem_reg_write),
        .exmem_rd       (bus.exmem_rd),
        .memwb_reg_write(bus.memwb_reg_write),
        .memwb_rd       (bus.memwb_rd),
        .fwd_a_sel      (w_fwd_a_sel),
        .fwd_b_sel      (w_fwd_b_sel)
    );

    always_comb begin
        case (w_fwd_a_sel)
            FWD_MEM: w_fwd_rs = bus.exmem_result;
            FWD_WB:  w_fwd_rs = bus.memwb_result;
            default: w_fwd_rs = r_rs_data;
        endcase
    end

    always_comb begin
        case (w_fwd_b_sel)
            FWD_MEM: w_fwd_rt = bus.exmem_result;
            FWD_WB:  w_fwd_rt = bus.memwb_result;
            default: w_fwd_rt = r_rt_data;
        endcase
    end

    assign bus.alu_a          = w_fwd_rs;
    assign bus.alu_b          = r_alu_src ? r_imm : w_fwd_rt;
    assign bus.ex_store_data  = w_fwd_rt;
    assign bus.alu_control    = r_alu_control;
    assign bus.ex_valid       = r_valid;
    assign bus.ex_reg_write   = r_reg_write;
    assign bus.ex_mem_read    = r_mem_read;
    assign bus.ex_mem_write   = r_mem_write;
    assign bus.ex_mem_to_reg  = r_mem_to_reg;
    assign bus.ex_rd          = r_rd;
    assign bus.load_use_stall = w_load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a slot-level reference model checked every
// cycle, plus hand-computed literal expectations at key points.
`timescale 1ns/1ps
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_stage_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

    id_ex_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what instruction occupies the EX slot.
    typedef struct packed {
        logic          valid;
        logic          rw;
        logic          mr;
        logic          mw;
        logic          m2r;
        logic          src;
        logic [3:0]    ctl;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] rd;
        logic [DW-1:0] rsd;
        logic [DW-1:0] rtd;
        logic [DW-1:0] imm;
    } slot_t;

    slot_t m;
    bit    started = 0;

    function automatic slot_t empty_slot();
        slot_t s;
        s = '0;
        s.ctl = 4'b0010;
        return s;
    endfunction

    function automatic logic [DW-1:0] value_of(input logic [AW-1:0] r, input logic [DW-1:0] file_val);
        if (r == 0) return file_val;
        if (bus.exmem_reg_write && bus.exmem_rd == r) return bus.exmem_result;
        if (bus.memwb_reg_write && bus.memwb_rd == r) return bus.memwb_result;
        return file_val;
    endfunction

    function automatic bit hazard();
        bit uses_rt;
        uses_rt = !bus.id_alu_src || bus.id_mem_write;
        if (bus.flush) return 0;
        if (!(m.valid && m.mr) || m.rd == 0) return 0;
        return (m.rd == bus.id_rs) || (uses_rt && m.rd == bus.id_rt);
    endfunction

    always @(posedge clk) begin
        bit h;
        h = hazard();
        if (rst || bus.flush) m = empty_slot();
        else if (bus.stall) m = m;
        else if (h || !bus.id_valid) m = empty_slot();
        else m = '{valid: 1'b1, rw: bus.id_reg_write, mr: bus.id_mem_read,
                   mw: bus.id_mem_write, m2r: bus.id_mem_to_reg, src: bus.id_alu_src,
                   ctl: bus.id_alu_control, rs: bus.id_rs, rt: bus.id_rt, rd: bus.id_rd,
                   rsd: bus.id_rs_data, rtd: bus.id_rt_data, imm: bus.id_imm};
        started = 1;
    end

    always @(negedge clk) begin
        logic [DW-1:0] rt_val;
        if (started) begin
            rt_val = value_of(m.rt, m.rtd);
            cmp("m_alu_a", bus.alu_a, value_of(m.rs, m.rsd));
            cmp("m_alu_b", bus.alu_b, m.src ? m.imm : rt_val);
            cmp("m_store", bus.ex_store_data, rt_val);
            cmp("m_ctl", DW'(bus.alu_control), DW'(m.ctl));
            cmp("m_valid", DW'(bus.ex_valid), DW'(m.valid));
            cmp("m_rw", DW'(bus.ex_reg_write), DW'(m.rw));
            cmp("m_mr", DW'(bus.ex_mem_read), DW'(m.mr));
            cmp("m_mw", DW'(bus.ex_mem_write), DW'(m.mw));
            cmp("m_m2r", DW'(bus.ex_mem_to_reg), DW'(m.m2r));
            cmp("m_rd", DW'(bus.ex_rd), DW'(m.rd));
            cmp("m_lus", DW'(bus.load_use_stall), DW'(hazard()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_id();
        bus.id_valid = 0; bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0;
        bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0; bus.id_alu_control = 4'b0010;
        bus.id_alu_src = 0; bus.id_reg_write = 0; bus.id_mem_read = 0;
        bus.id_mem_write = 0; bus.id_mem_to_reg = 0;
    endtask

    task automatic clear_fwd();
        bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
        bus.memwb_reg_write = 0; bus.memwb_rd = 0; bus.memwb_result = 0;
    endtask

    task automatic drive_id(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                            input logic [DW-1:0] rsd, input logic [DW-1:0] rtd, input logic [DW-1:0] imm,
                            input logic src, input logic rw, input logic mr, input logic mw, input logic m2r);
        bus.id_valid = 1; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
        bus.id_rs_data = rsd; bus.id_rt_data = rtd; bus.id_imm = imm;
        bus.id_alu_control = 4'b0010; bus.id_alu_src = src; bus.id_reg_write = rw;
        bus.id_mem_read = mr; bus.id_mem_write = mw; bus.id_mem_to_reg = m2r;
    endtask

    initial begin
        rst = 1;
        bus.stall = 0; bus.flush = 0;
        idle_id();
        clear_fwd();
        tick(); tick();
        rst = 0;

        // reset / idle
        look();
        cmp("rst_ctl", DW'(bus.alu_control), 32'h2);
        cmp("rst_a", bus.alu_a, 0);
        cmp("rst_b", bus.alu_b, 0);
        cmp("rst_valid", DW'(bus.ex_valid), 0);
        cmp("rst_rw", DW'(bus.ex_reg_write), 0);
        tick();

        // ADD with rs forwarded from EX/MEM, held by stall for further probes
        drive_id(5'd3, 5'd4, 5'd5, 32'd5, 32'd7, 32'd0, 0, 1, 0, 0, 0);
        tick();
        idle_id();
        bus.stall = 1;
        bus.exmem_reg_write = 1; bus.exmem_rd = 5'd3; bus.exmem_result = 32'd100;
        look();
        cmp("add_fwd_a", bus.alu_a, 32'd100);
        cmp("add_b", bus.alu_b, 32'd7);
        cmp("add_valid", DW'(bus.ex_valid), 1);
        tick();
        bus.exmem_rd = 5'd4; bus.exmem_result = 32'h11;
        bus.memwb_reg_write = 1; bus.memwb_rd = 5'd4; bus.memwb_result = 32'h22;
        look();
        cmp("mem_over_wb", bus.alu_b, 32'h11);
        cmp("mem_over_wb_a", bus.alu_a, 32'd5);
        tick();
        bus.exmem_rd = 5'd0; bus.memwb_rd = 5'd0;
        look();
        cmp("r0_no_fwd", bus.alu_b, 32'd7);
        tick();
        bus.stall = 0;
        clear_fwd();

        // load-use: lw r8 then add using r8
        drive_id(5'd1, 5'd8, 5'd8, 32'h100, 32'd0, 32'd4, 1, 1, 1, 0, 1);
        tick();
        drive_id(5'd8, 5'd2, 5'd9, 32'd0, 32'd3, 32'd0, 0, 1, 0, 0, 0);
        look();
        cmp("lu_stall", DW'(bus.load_use_stall), 1);
        cmp("lu_ex_lw", DW'(bus.ex_mem_read), 1);
        bus.flush = 1;
        #1;
        cmp("lu_flush_kill", DW'(bus.load_use_stall), 0);
        bus.flush = 0;
        drive_id(5'd0, 5'd8, 5'd0, 32'd0, 32'd0, 32'd8, 1, 0, 0, 1, 0);
        #1;
        cmp("lu_store_rt", DW'(bus.load_use_stall), 1);
        bus.id_mem_write = 0;
        #1;
        cmp("lu_imm_rt_free", DW'(bus.load_use_stall), 0);
        drive_id(5'd8, 5'd2, 5'd9, 32'd0, 32'd3, 32'd0, 0, 1, 0, 0, 0);
        tick();
        bus.exmem_reg_write = 1; bus.exmem_rd = 5'd8; bus.exmem_result = 32'h104;
        look();
        cmp("lu_bubble", DW'(bus.ex_valid), 0);
        cmp("lu_released", DW'(bus.load_use_stall), 0);
        tick();
        clear_fwd();
        bus.memwb_reg_write = 1; bus.memwb_rd = 5'd8; bus.memwb_result = 32'h55;
        look();
        cmp("lu_fwd_wb", bus.alu_a, 32'h55);
        cmp("lu_b", bus.alu_b, 32'd3);
        cmp("lu_rd", DW'(bus.ex_rd), 32'd9);

        // store with immediate, rt forwarded from EX/MEM
        drive_id(5'd9, 5'd6, 5'd0, 32'h200, 32'd1, 32'h10, 1, 0, 0, 1, 0);
        tick();
        clear_fwd();
        bus.exmem_reg_write = 1; bus.exmem_rd = 5'd6; bus.exmem_result = 32'hCAFE;
        look();
        cmp("st_b_imm", bus.alu_b, 32'h10);
        cmp("st_data", bus.ex_store_data, 32'hCAFE);
        cmp("st_a", bus.alu_a, 32'h200);
        cmp("st_mw", DW'(bus.ex_mem_write), 1);

        // control priority: stall, stall, flush+stall, load, rst+stall
        drive_id(5'd1, 5'd2, 5'd3, 32'd11, 32'd22, 32'd0, 0, 1, 0, 0, 0);
        clear_fwd();
        bus.stall = 1;
        tick();
        look();
        cmp("hold1_mw", DW'(bus.ex_mem_write), 1);
        cmp("hold1_b", bus.alu_b, 32'h10);
        tick();
        look();
        cmp("hold2_store", bus.ex_store_data, 32'd1);
        bus.flush = 1;
        tick();
        look();
        cmp("flush_valid", DW'(bus.ex_valid), 0);
        cmp("flush_ctl", DW'(bus.alu_control), 32'h2);
        cmp("flush_mw", DW'(bus.ex_mem_write), 0);
        bus.flush = 0;
        bus.stall = 0;
        tick();
        look();
        cmp("reload_a", bus.alu_a, 32'd11);
        bus.stall = 1;
        rst = 1;
        tick();
        rst = 0;
        look();
        cmp("rst_mid_valid", DW'(bus.ex_valid), 0);
        cmp("rst_mid_a", bus.alu_a, 0);
        cmp("rst_mid_rd", DW'(bus.ex_rd), 0);
        cmp("rst_mid_ctl", DW'(bus.alu_control), 32'h2);
        bus.stall = 0;
        idle_id();
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
